// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: request/response sequencer around an external combinational add/sub stage
// Registers operands, captures the result with zero/overflow flags, and keeps a chaining accumulator.
module addsub_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_m,
    input  logic         in_acc,
    input  logic         acc_clr,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_m,
    input  logic [W-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_cout,
    output logic         out_zero,
    output logic         out_ovf,
    output logic [W-1:0] acc
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, s_q, s_d, acc_q, acc_d;
    logic           m_q, m_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic           ovf;

    // Subtraction flips the sign-agreement test because B enters the adder inverted.
    assign ovf = (m_q ? (a_q[W-1] != b_q[W-1]) : (a_q[W-1] == b_q[W-1]))
                 && (add_s[W-1] != a_q[W-1]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        acc_d   = acc_clr ? '0 : acc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_acc ? acc_q : in_a;
                b_d     = in_b;
                m_d     = in_m;
                state_d = EXEC;
            end
            EXEC: begin
                s_d     = add_s;
                cout_d  = add_cout;
                zero_d  = (add_s == '0);
                ovf_d   = ovf;
                acc_d   = acc_clr ? '0 : add_s;
                state_d = RESP;
            end
            RESP: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_m     = m_q;
    assign out_s     = s_q;
    assign out_cout  = cout_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign acc       = acc_q;
endmodule
